// File: rtl/tela_fim_jogo_pkg.sv
// Shared definitions for the end-of-game screen renderer.
// Holds the sprite size, the trophy bitmap (one 11-bit mask per row, col 0 at
// the MSB), the FSM state encoding and the full-brightness base colours.
package tela_fim_jogo_pkg;

    localparam int SPRITE_DIM = 11;

    localparam logic [10:0] TROPHY_R0  = 11'b00111111100;
    localparam logic [10:0] TROPHY_R1  = 11'b11111111111;
    localparam logic [10:0] TROPHY_R2  = 11'b10111111101;
    localparam logic [10:0] TROPHY_R3  = 11'b10111111101;
    localparam logic [10:0] TROPHY_R4  = 11'b11111111111;
    localparam logic [10:0] TROPHY_R5  = 11'b00111111100;
    localparam logic [10:0] TROPHY_R6  = 11'b00001110000;
    localparam logic [10:0] TROPHY_R7  = 11'b00001110000;
    localparam logic [10:0] TROPHY_R8  = 11'b00001110000;
    localparam logic [10:0] TROPHY_R9  = 11'b00001110000;
    localparam logic [10:0] TROPHY_R10 = 11'b00111111100;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FADE_IN = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    // {R,G,B} at full brightness
    localparam logic [23:0] BASE_VICTORY = 24'hFFFF00;
    localparam logic [23:0] BASE_DEFEAT  = 24'hFF0000;

    function automatic logic [10:0] trophy_row(input logic [3:0] row);
        logic [10:0] mask;
        case (row)
            4'd0:    mask = TROPHY_R0;
            4'd1:    mask = TROPHY_R1;
            4'd2:    mask = TROPHY_R2;
            4'd3:    mask = TROPHY_R3;
            4'd4:    mask = TROPHY_R4;
            4'd5:    mask = TROPHY_R5;
            4'd6:    mask = TROPHY_R6;
            4'd7:    mask = TROPHY_R7;
            4'd8:    mask = TROPHY_R8;
            4'd9:    mask = TROPHY_R9;
            4'd10:   mask = TROPHY_R10;
            default: mask = '0;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/tela_fim_jogo_sprite_rom.sv
// Combinational sprite lookup for the end-of-game screen.
// Ports:
//   mode in  1  0 = trophy, 1 = X
//   row  in  4  sprite cell row (0..10; larger values read as unlit)
//   col  in  4  sprite cell column (0..10; larger values read as unlit)
//   lit  out 1  cell is part of the sprite
module tela_fim_sprite_rom
    import tela_fim_jogo_pkg::*;
(
    input  logic       mode,
    input  logic [3:0] row,
    input  logic [3:0] col,
    output logic       lit
);

    logic [10:0] row_mask;

    always_comb begin
        lit      = 1'b0;
        row_mask = trophy_row(row);
        if (row < 4'(SPRITE_DIM) && col < 4'(SPRITE_DIM)) begin
            if (mode) begin
                // both diagonals of the 11x11 grid
                lit = (col == row) || (col == 4'(SPRITE_DIM - 1) - row);
            end else begin
                // column 0 is stored in the MSB of each row mask
                lit = row_mask[4'(SPRITE_DIM - 1) - col];
            end
        end
    end

endmodule

// File: rtl/tela_fim_jogo.sv
// End-of-game screen renderer. Draws an 11x11 sprite (trophy for victory,
// X for defeat) scaled by SCALE at (ORIGIN_X, ORIGIN_Y), fades it in over
// 16 brightness steps of FADE_FRAMES frames each, then optionally blinks it.
// Ports:
//   clk        in   1   system clock
//   reset      in   1   asynchronous, active-high reset
//   show       in   1   level; high while the screen is requested
//   mode       in   1   0 victory, 1 defeat; captured when the screen starts
//   h_counter  in   10  current pixel column
//   v_counter  in   10  current pixel line
//   R,G,B      out  8   registered pixel colour for the h/v of the previous clk
//   done       out  1   high while the fade is complete (HOLD)
module tela_fim_jogo
    import tela_fim_jogo_pkg::*;
#(
    parameter int          SCALE        = 10,
    parameter int          ORIGIN_X     = 400,
    parameter int          ORIGIN_Y     = 200,
    parameter int          H_ACTIVE     = 640,
    parameter int          V_ACTIVE     = 480,
    parameter int          FRAME_LINE   = 480,
    parameter int          FADE_FRAMES  = 4,
    parameter int          BLINK_FRAMES = 30,
    parameter logic [23:0] BG_RGB       = 24'h0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       show,
    input  logic       mode,
    input  logic [9:0] h_counter,
    input  logic [9:0] v_counter,
    output logic [7:0] R,
    output logic [7:0] G,
    output logic [7:0] B,
    output logic       done
);

    localparam int FADE_W  = (FADE_FRAMES  > 1) ? $clog2(FADE_FRAMES + 1)  : 1;
    localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES + 1) : 1;

    localparam logic [FADE_W-1:0]  FADE_LAST  = FADE_W'(FADE_FRAMES - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = (BLINK_FRAMES > 0) ? BLINK_W'(BLINK_FRAMES - 1) : '0;

    localparam logic [15:0] BOX_X0  = 16'(ORIGIN_X);
    localparam logic [15:0] BOX_X1  = 16'(ORIGIN_X + SPRITE_DIM * SCALE);
    localparam logic [15:0] BOX_Y0  = 16'(ORIGIN_Y);
    localparam logic [15:0] BOX_Y1  = 16'(ORIGIN_Y + SPRITE_DIM * SCALE);
    localparam logic [15:0] SCALE_L = 16'(SCALE);
    localparam logic [15:0] H_LIM   = 16'(H_ACTIVE);
    localparam logic [15:0] V_LIM   = 16'(V_ACTIVE);

    // (base * level) >> 4; level 16 reproduces the base value exactly
    function automatic logic [7:0] fade_chan(input logic [7:0] base, input logic [4:0] lvl);
        logic [12:0] prod;
        prod = 13'(base) * 13'(lvl);
        return 8'(prod >> 4);
    endfunction

    state_t               state, state_nxt;
    logic [4:0]           level, level_nxt;
    logic                 blink_on, blink_on_nxt;
    logic                 mode_q, mode_q_nxt;
    logic [FADE_W-1:0]    cnt, cnt_nxt;
    logic [BLINK_W-1:0]   blink_cnt, blink_cnt_nxt;
    logic                 show_q;
    logic [9:0]           prev_v;
    logic                 frame_tick;

    // The pixel clock may be slower than clk, so the tick is taken on the
    // first clk that sees v_counter enter FRAME_LINE.
    assign frame_tick = (v_counter == 10'(FRAME_LINE)) && (prev_v != 10'(FRAME_LINE));
    assign done       = (state == ST_HOLD);

    // show_q resets high so a show held through reset release is not seen as
    // a new request; the screen waits for show to fall and rise again.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            level     <= '0;
            blink_on  <= 1'b1;
            mode_q    <= 1'b0;
            cnt       <= '0;
            blink_cnt <= '0;
            show_q    <= 1'b1;
            prev_v    <= '0;
        end else begin
            state     <= state_nxt;
            level     <= level_nxt;
            blink_on  <= blink_on_nxt;
            mode_q    <= mode_q_nxt;
            cnt       <= cnt_nxt;
            blink_cnt <= blink_cnt_nxt;
            show_q    <= show;
            prev_v    <= v_counter;
        end
    end

    always_comb begin
        state_nxt     = state;
        level_nxt     = level;
        blink_on_nxt  = blink_on;
        mode_q_nxt    = mode_q;
        cnt_nxt       = cnt;
        blink_cnt_nxt = blink_cnt;

        if (!show) begin
            state_nxt = ST_IDLE;
            level_nxt = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    level_nxt = '0;
                    // a tick coinciding with the start is simply not counted
                    if (!show_q) begin
                        state_nxt    = ST_FADE_IN;
                        mode_q_nxt   = mode;
                        cnt_nxt      = '0;
                        blink_on_nxt = 1'b1;
                    end
                end
                ST_FADE_IN: begin
                    if (frame_tick) begin
                        if (cnt == FADE_LAST) begin
                            cnt_nxt   = '0;
                            level_nxt = level + 5'd1;
                            if (level == 5'd15) begin
                                state_nxt     = ST_HOLD;
                                blink_on_nxt  = 1'b1;
                                blink_cnt_nxt = '0;
                            end
                        end else begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (BLINK_FRAMES > 0 && frame_tick) begin
                        if (blink_cnt == BLINK_LAST) begin
                            blink_cnt_nxt = '0;
                            blink_on_nxt  = ~blink_on;
                        end else begin
                            blink_cnt_nxt = blink_cnt + 1'b1;
                        end
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Pixel path
    logic [15:0] h_ext, v_ext, h_off, v_off;
    logic [3:0]  col, row;
    logic        in_area, in_box, rom_lit;
    logic [23:0] base_rgb, pix_nxt;

    assign h_ext = 16'(h_counter);
    assign v_ext = 16'(v_counter);
    assign h_off = h_ext - BOX_X0;
    assign v_off = v_ext - BOX_Y0;
    // only meaningful inside the box; the ROM treats out-of-range cells as unlit
    assign col   = 4'(h_off / SCALE_L);
    assign row   = 4'(v_off / SCALE_L);

    tela_fim_sprite_rom u_rom (
        .mode (mode_q),
        .row  (row),
        .col  (col),
        .lit  (rom_lit)
    );

    always_comb begin
        in_area  = (h_ext < H_LIM) && (v_ext < V_LIM);
        in_box   = (h_ext >= BOX_X0) && (h_ext < BOX_X1) && (v_ext >= BOX_Y0) && (v_ext < BOX_Y1);
        base_rgb = mode_q ? BASE_DEFEAT : BASE_VICTORY;
        pix_nxt  = '0;
        // gating on show directly blanks the very next pixel after show drops
        if (show && state != ST_IDLE && in_area) begin
            if (in_box && rom_lit && blink_on) begin
                pix_nxt = {fade_chan(base_rgb[23:16], level),
                           fade_chan(base_rgb[15:8],  level),
                           fade_chan(base_rgb[7:0],   level)};
            end else begin
                pix_nxt = BG_RGB;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {R, G, B} <= '0;
        end else begin
            {R, G, B} <= pix_nxt;
        end
    end

endmodule

// File: tb/tb_tela_fim_jogo.sv
module tb_tela_fim_jogo;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       show = 1'b0;
    logic       mode = 1'b0;
    logic [9:0] h_counter = '0;
    logic [9:0] v_counter = '0;
    logic [7:0] R_a, G_a, B_a, R_b, G_b, B_b;
    logic       done_a, done_b;

    always #5 clk = ~clk;

    // Instance A blinks every 2 ticks, instance B never blinks.
    tela_fim_jogo #(.FADE_FRAMES(1), .BLINK_FRAMES(2)) dut_a (
        .clk(clk), .reset(reset), .show(show), .mode(mode),
        .h_counter(h_counter), .v_counter(v_counter),
        .R(R_a), .G(G_a), .B(B_a), .done(done_a)
    );

    tela_fim_jogo #(.FADE_FRAMES(1), .BLINK_FRAMES(0)) dut_b (
        .clk(clk), .reset(reset), .show(show), .mode(mode),
        .h_counter(h_counter), .v_counter(v_counter),
        .R(R_b), .G(G_b), .B(B_b), .done(done_b)
    );

    localparam int FADE = 1;
    localparam logic [10:0] TROPHY [11] = '{
        11'b00111111100, 11'b11111111111, 11'b10111111101, 11'b10111111101,
        11'b11111111111, 11'b00111111100, 11'b00001110000, 11'b00001110000,
        11'b00001110000, 11'b00001110000, 11'b00111111100};

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: the screen is either off or "running since start",
    // characterised only by the number of frame ticks counted since start.
    bit m_active    = 0;
    bit m_mode      = 0;
    int m_ticks     = 0;
    bit m_prev_show = 1;
    int m_prev_v    = 0;

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %06h expected %06h at %0t", name, act, exp, $time);
    endtask

    function automatic bit sprite_lit(input bit md, input int row, input int col);
        logic [10:0] m;
        if (md) return (col == row) || (col == 10 - row);
        m = TROPHY[row];
        return m[10 - col];
    endfunction

    function automatic logic [23:0] model_pix(input int h, input int v, input bit s, input int bf);
        int row, col, lvl, r, g;
        bit blink;
        if (!s || !m_active || h >= 640 || v >= 480) return 24'h0;
        if (h < 400 || h >= 510 || v < 200 || v >= 310) return 24'h0;
        col = (h - 400) / 10;
        row = (v - 200) / 10;
        lvl = m_ticks / FADE;
        if (lvl > 16) lvl = 16;
        blink = 1;
        if (bf > 0 && m_ticks >= 16 * FADE) blink = (((m_ticks - 16 * FADE) / bf) % 2) == 0;
        if (!blink || !sprite_lit(m_mode, row, col)) return 24'h0;
        r = 255;
        g = m_mode ? 0 : 255;
        return {8'((r * lvl) / 16), 8'((g * lvl) / 16), 8'h00};
    endfunction

    task automatic model_reset();
        m_active = 0; m_ticks = 0; m_prev_show = 1; m_prev_v = 0;
    endtask

    // Drive one clk worth of inputs, advance the model, and compare after the edge.
    task automatic step(input bit s, input bit md, input int h, input int v);
        logic [23:0] ea, eb;
        bit tick;
        show = s; mode = md; h_counter = 10'(h); v_counter = 10'(v);
        ea = model_pix(h, v, s, 2);
        eb = model_pix(h, v, s, 0);
        tick = (v == 480) && (m_prev_v != 480);
        if (!s) begin
            m_active = 0; m_ticks = 0;
        end else if (!m_active && !m_prev_show) begin
            m_active = 1; m_mode = md; m_ticks = 0;
        end else if (m_active && tick) begin
            m_ticks++;
        end
        m_prev_show = s;
        m_prev_v = v;
        @(posedge clk); #1;
        check("pix_a", {R_a, G_a, B_a}, ea);
        check("pix_b", {R_b, G_b, B_b}, eb);
        check("done_a", 24'(done_a), 24'(m_active && m_ticks >= 16 * FADE));
        check("done_b", 24'(done_b), 24'(m_active && m_ticks >= 16 * FADE));
    endtask

    task automatic tick_frames(input int n, input bit md);
        for (int i = 0; i < n; i++) begin
            step(1, md, 0, 480);
            step(1, md, 0, 0);
        end
    endtask

    task automatic async_reset();
        #2 reset = 1'b1;
        #1;
        model_reset();
        check("rst_rgb_a", {R_a, G_a, B_a}, 24'h0);
        check("rst_done_a", 24'(done_a), 24'h0);
        check("rst_rgb_b", {R_b, G_b, B_b}, 24'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
    endtask

    typedef struct {
        int          h;
        int          v;
        logic [23:0] exp;
    } vec_t;

    vec_t hold_vec [9];

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit cur_show;
        int h, v;

        hold_vec[0] = '{425, 205, 24'hFFFF00};
        hold_vec[1] = '{405, 205, 24'h000000};
        hold_vec[2] = '{515, 205, 24'h000000};
        hold_vec[3] = '{420, 200, 24'hFFFF00};
        hold_vec[4] = '{400, 210, 24'hFFFF00};
        hold_vec[5] = '{509, 309, 24'h000000};
        hold_vec[6] = '{450, 300, 24'hFFFF00};
        hold_vec[7] = '{700, 205, 24'h000000};
        hold_vec[8] = '{425, 479, 24'h000000};

        // power-up reset
        async_reset();
        step(0, 0, 425, 205);

        // victory fade with one level per tick
        step(1, 0, 0, 0);
        tick_frames(15, 0);
        check("done_before_16", 24'(done_a), 24'h0);
        step(1, 0, 0, 480);
        check("done_after_16", 24'(done_a), 24'h1);
        step(1, 0, 0, 0);

        for (int i = 0; i < 9; i++) begin
            step(1, 0, hold_vec[i].h, hold_vec[i].v);
            check($sformatf("hold_a_%0d", i), {R_a, G_a, B_a}, hold_vec[i].exp);
            check($sformatf("hold_b_%0d", i), {R_b, G_b, B_b}, hold_vec[i].exp);
        end

        // blink: A goes dark after 2 ticks and back after 2 more; B stays lit
        tick_frames(2, 0);
        step(1, 0, 425, 205);
        check("blink_off_a", {R_a, G_a, B_a}, 24'h000000);
        check("noblink_b", {R_b, G_b, B_b}, 24'hFFFF00);
        tick_frames(2, 0);
        step(1, 0, 425, 205);
        check("blink_on_a", {R_a, G_a, B_a}, 24'hFFFF00);

        // drop show, restart as defeat, drop mid-fade
        step(0, 0, 425, 205);
        check("drop_rgb", {R_a, G_a, B_a}, 24'h0);
        check("drop_done", 24'(done_a), 24'h0);
        step(1, 1, 0, 0);
        tick_frames(4, 0);
        step(0, 1, 405, 205);
        check("midfade_drop_rgb", {R_b, G_b, B_b}, 24'h0);
        check("midfade_drop_done", 24'(done_b), 24'h0);
        step(1, 1, 0, 0);
        tick_frames(8, 0);
        step(1, 0, 400, 200);
        check("mid_x_corner", {R_a, G_a, B_a}, 24'h7F0000);
        step(1, 0, 700, 200);
        check("mid_offscreen", {R_a, G_a, B_a}, 24'h000000);
        step(1, 0, 405, 205);
        check("mid_x_lit", {R_a, G_a, B_a}, 24'h7F0000);
        step(1, 0, 425, 205);
        check("mid_x_bg", {R_a, G_a, B_a}, 24'h000000);

        // start coinciding with a tick: that tick is not counted
        step(0, 0, 0, 0);
        step(1, 0, 0, 480);
        step(1, 0, 0, 0);
        tick_frames(15, 0);
        check("start_tick_done0", 24'(done_a), 24'h0);
        tick_frames(1, 0);
        check("start_tick_done1", 24'(done_a), 24'h1);

        // reset during HOLD with show held high
        async_reset();
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 425, 205);
            check("post_rst_idle", {R_a, G_a, B_a, 8'(done_a)}, 32'h0);
        end
        tick_frames(2, 0);
        check("post_rst_no_fade", 24'(done_a), 24'h0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        tick_frames(16, 0);
        step(1, 0, 425, 205);
        check("post_rst_restart", {R_b, G_b, B_b}, 24'hFFFF00);

        // randomized traffic against the model
        cur_show = 1;
        for (int i = 0; i < 3000; i++) begin
            if (cur_show) begin
                if ($urandom_range(999) < 3) cur_show = 0;
            end else if ($urandom_range(99) < 25) begin
                cur_show = 1;
            end
            if ($urandom_range(99) < 60) h = int'($urandom_range(520, 390));
            else h = int'($urandom_range(1023));
            if ($urandom_range(99) < 10) v = 480;
            else if ($urandom_range(99) < 60) v = int'($urandom_range(320, 190));
            else v = int'($urandom_range(1023));
            step(cur_show, 1'($urandom_range(1)), h, v);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
